// File: rtl/seq_divider.sv
// seq_divider: sequential unsigned restoring divider, one quotient bit per clock.
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst        synchronous reset, active-high, overrides start
//   start      request; only sampled while idle
//   dividend   DW-bit unsigned dividend, captured when start is accepted
//   divisor    VW-bit unsigned divisor, captured when start is accepted
//   busy       high while iterating
//   done       one-cycle pulse when quotient/remainder/div_zero become valid
//   quotient   DW-bit result, held until the next done pulse
//   remainder  VW-bit result, held until the next done pulse
//   div_zero   last operation had a zero divisor, held with the results
module seq_divider #(
   parameter int unsigned DW = 8,
   parameter int unsigned VW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          div_zero
);

   localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

   state_t        state;
   logic [DW-1:0] q_sr;   // dividend shifts out MSB-first, quotient bits shift in at LSB
   logic [VW-1:0] d_r;
   logic [VW:0]   r_r;    // partial remainder with carry guard bit
   logic [CW-1:0] cnt;

   logic [VW:0]   r_shift;
   logic [VW+1:0] trial;
   logic [VW:0]   r_next;
   logic [DW-1:0] q_next;

   // One restoring step. r_r stays below the divisor between steps, so its guard
   // bit is zero and {r_r, msb} equals the left-shifted remainder; the extra
   // top bit of trial acts as the sign of the trial subtraction.
   always_comb begin
      r_shift = {r_r[VW-1:0], q_sr[DW-1]};
      trial   = {r_r, q_sr[DW-1]} - {2'b00, d_r};
      r_next  = r_shift;
      q_next  = {q_sr[DW-2:0], 1'b0};
      if (!trial[VW+1]) begin
         r_next = trial[VW:0];
         q_next = {q_sr[DW-2:0], 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= StIdle;
         q_sr      <= '0;
         d_r       <= '0;
         r_r       <= '0;
         cnt       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         div_zero  <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            StIdle: begin
               if (start) begin
                  q_sr <= dividend;
                  d_r  <= divisor;
                  r_r  <= '0;
                  cnt  <= '0;
                  if (divisor == '0) begin
                     // No iterations: report saturated quotient immediately.
                     state     <= StDone;
                     done      <= 1'b1;
                     quotient  <= '1;
                     remainder <= '0;
                     div_zero  <= 1'b1;
                  end else begin
                     state <= StCalc;
                     busy  <= 1'b1;
                  end
               end
            end
            StCalc: begin
               q_sr <= q_next;
               r_r  <= r_next;
               cnt  <= cnt + 1'b1;
               if (cnt == CW'(DW - 1)) begin
                  // Last step: publish the results on the same edge as done.
                  state     <= StDone;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  quotient  <= q_next;
                  remainder <= r_next[VW-1:0];
                  div_zero  <= 1'b0;
               end
            end
            StDone: begin
               state <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

   localparam int unsigned DW = 8;
   localparam int unsigned VW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [DW-1:0] dividend = '0;
   logic [VW-1:0] divisor = '0;
   logic          busy;
   logic          done;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          div_zero;

   typedef struct {
      logic [DW-1:0] a;
      logic [VW-1:0] d;
      logic [DW-1:0] q;
      logic [VW-1:0] r;
      logic          dz;
      int            cyc;
   } exp_t;

   exp_t sb[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Outputs the DUT must hold while no done pulse is present.
   logic [DW-1:0] hold_q = '0;
   logic [VW-1:0] hold_r = '0;
   logic          hold_dz = 1'b0;

   seq_divider #(.DW(DW), .VW(VW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard on every done pulse, otherwise checks hold.
   always @(negedge clk) begin
      exp_t e;
      if (done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
            hold_q  = quotient;
            hold_r  = remainder;
            hold_dz = div_zero;
         end else begin
            e = sb.pop_front();
            check("done_cycle", cyc, e.cyc);
            check("quotient", 32'(quotient), 32'(e.q));
            check("remainder", 32'(remainder), 32'(e.r));
            check("div_zero", 32'(div_zero), 32'(e.dz));
            check("busy_at_done", 32'(busy), 32'd0);
            if (e.d != '0) begin
               check("q_times_d_plus_r", int'(quotient) * int'(e.d) + int'(remainder), int'(e.a));
               check("r_lt_d", 32'(remainder < e.d), 32'd1);
            end
            hold_q  = e.q;
            hold_r  = e.r;
            hold_dz = e.dz;
         end
      end else begin
         check("hold_outputs", 32'({quotient, remainder, div_zero}),
               32'({hold_q, hold_r, hold_dz}));
      end
   end

   task automatic wait_done(output int bc);
      bit seen;
      bc = 0;
      seen = 1'b0;
      for (int i = 0; i < int'(DW) + 4 && !seen; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy) bc++;
         if (done) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done expected done within %0d cycles", DW + 4);
      end
   endtask

   task automatic issue(input logic [DW-1:0] a, input logic [VW-1:0] d, input logic [DW-1:0] q,
                        input logic [VW-1:0] r, input logic dz);
      exp_t e;
      @(negedge clk);
      start    = 1'b1;
      dividend = a;
      divisor  = d;
      e.a   = a;
      e.d   = d;
      e.q   = q;
      e.r   = r;
      e.dz  = dz;
      e.cyc = cyc + 1 + ((d == '0) ? 0 : int'(DW));
      sb.push_back(e);
   endtask

   task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] d, input logic [DW-1:0] q,
                         input logic [VW-1:0] r, input logic dz);
      int bc;
      issue(a, d, q, r, dz);
      wait_done(bc);
      check("busy_cycles", bc, (d == '0) ? 0 : int'(DW));
   endtask

   initial begin
      int bc;
      logic [DW-1:0] eq;
      logic [VW-1:0] er;

      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_quotient", 32'(quotient), 32'd0);
      check("rst_remainder", 32'(remainder), 32'd0);
      check("rst_div_zero", 32'(div_zero), 32'd0);
      rst = 1'b0;

      // Directed vectors.
      run_op(8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
      run_op(8'd255, 4'd15, 8'd17, 4'd0, 1'b0);
      run_op(8'd5, 4'd9, 8'd0, 4'd5, 1'b0);
      run_op(8'd0, 4'd1, 8'd0, 4'd0, 1'b0);
      run_op(8'd100, 4'd0, 8'hFF, 4'd0, 1'b1);
      run_op(8'd9, 4'd3, 8'd3, 4'd0, 1'b0);

      // A start pulsed mid-calculation must be ignored.
      issue(8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      start    = 1'b1;
      dividend = 8'd50;
      divisor  = 4'd5;
      @(negedge clk);
      start = 1'b0;
      wait_done(bc);
      repeat (DW + 3) @(negedge clk);

      // Reset mid-calculation aborts without a done pulse.
      @(negedge clk);
      start    = 1'b1;
      dividend = 8'd200;
      divisor  = 4'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      hold_q  = '0;
      hold_r  = '0;
      hold_dz = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_quotient", 32'(quotient), 32'd0);
      check("abort_remainder", 32'(remainder), 32'd0);
      check("abort_div_zero", 32'(div_zero), 32'd0);
      repeat (DW + 2) @(negedge clk);
      run_op(8'd77, 4'd6, 8'd12, 4'd5, 1'b0);

      // Full operand sweep.
      for (int a = 0; a < 256; a++) begin
         for (int d = 0; d < 16; d++) begin
            if (d == 0) begin
               eq = 8'hFF;
               er = 4'd0;
            end else begin
               eq = 8'(a / d);
               er = 4'(a % d);
            end
            run_op(8'(a), 4'(d), eq, er, (d == 0));
         end
      end

      repeat (5) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
